// File: rtl/imem_loadable.sv
// imem_loadable: synchronous instruction memory for the fetch stage with a
// runtime program-load stream, fetch stall, flush-to-NOP and out-of-range
// PC detection. The array is not reset, so a loaded program survives rst_n.
module imem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              CLK_SYS,
  input  logic              rst_n,
  // fetch side
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_err,
  // loader side
  input  logic              load_en,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  // Index width into the array; pc/wptr are sliced down to it once range
  // has been established.
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_wptr;
  logic [DATA_W-1:0] r_instr;
  logic              r_vld;
  logic              r_err;
  logic              r_done;
  logic [ADDR_W:0]   r_cnt;

  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_ready;
  logic              w_xfer;
  logic              w_cmpl;

  assign w_in_range = ({1'b0, pc} < DEPTH_C);
  assign w_rd_data  = r_mem[pc[IDX_W-1:0]];

  // Ready only while actively loading; dropping load_en blocks the write
  // on the abort cycle itself.
  assign w_wr_ready = (r_state == S_LOAD) & load_en;
  assign w_xfer     = w_wr_ready & wr_valid;
  // Finish on the tagged last word, or when the array is full so later
  // words are never written past DEPTH-1.
  assign w_cmpl     = w_xfer & (wr_last | (r_wptr == LAST_PTR));

  assign instruction = r_instr;
  assign instr_valid = r_vld;
  assign addr_err    = r_err;
  assign wr_ready    = w_wr_ready;
  assign load_done   = r_done;
  assign load_count  = r_cnt;

  // Array write port: no reset so contents persist across rst_n.
  always_ff @(posedge CLK_SYS) begin
    if (w_xfer) r_mem[r_wptr[IDX_W-1:0]] <= wr_data;
  end

  // RUN/LOAD control with registered fetch and loader status outputs.
  always_ff @(posedge CLK_SYS or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_wptr  <= '0;
      r_instr <= NOP_WORD;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (load_en) begin
            // load request beats any fetch issued the same cycle
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_instr <= NOP_WORD;
            r_vld   <= 1'b0;
          end else if (flush) begin
            r_instr <= NOP_WORD;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
          end else if (fetch_en) begin
            r_instr <= w_in_range ? w_rd_data : NOP_WORD;
            r_vld   <= 1'b1;
            r_err   <= ~w_in_range;
          end
          // fetch_en=0: outputs hold (stall)
        end
        S_LOAD: begin
          // fetch side is parked on NOP while the program is replaced
          r_instr <= NOP_WORD;
          r_vld   <= 1'b0;
          if (!load_en) begin
            r_state <= S_RUN;
            r_cnt   <= {1'b0, r_wptr};
          end else if (w_cmpl) begin
            r_state <= S_RUN;
            r_cnt   <= {1'b0, r_wptr} + (ADDR_W+1)'(1);
            r_done  <= 1'b1;
          end else if (w_xfer) begin
            r_wptr  <= r_wptr + ADDR_W'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: default build (DEPTH=1024) plus a DEPTH=8 build
// for out-of-range and overflow-guard behaviour.
module tb_imem_loadable;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic        fetch_en, flush, load_en, wr_valid, wr_last;
  logic [9:0]  pc;
  logic [31:0] wr_data, instruction;
  logic        instr_valid, addr_err, wr_ready, load_done;
  logic [10:0] load_count;

  // DEPTH=8 build
  logic        b_fetch_en, b_flush, b_load_en, b_wr_valid, b_wr_last;
  logic [3:0]  b_pc;
  logic [31:0] b_wr_data, b_instruction;
  logic        b_instr_valid, b_addr_err, b_wr_ready, b_load_done;
  logic [4:0]  b_load_count;

  imem_loadable u_dut (
    .CLK_SYS(clk), .rst_n(rst_n),
    .fetch_en(fetch_en), .pc(pc), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid), .addr_err(addr_err),
    .load_en(load_en), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .load_done(load_done), .load_count(load_count)
  );

  imem_loadable #(.DATA_W(32), .ADDR_W(4), .DEPTH(8)) u_d8 (
    .CLK_SYS(clk), .rst_n(rst_n),
    .fetch_en(b_fetch_en), .pc(b_pc), .flush(b_flush),
    .instruction(b_instruction), .instr_valid(b_instr_valid), .addr_err(b_addr_err),
    .load_en(b_load_en), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_last(b_wr_last),
    .wr_ready(b_wr_ready), .load_done(b_load_done), .load_count(b_load_count)
  );

  typedef struct {
    logic        sel;
    string       nm;
    logic [31:0] ins;
    logic        v;
    logic        e;
  } exp_t;

  typedef struct {
    logic        fe;
    logic        fl;
    logic [9:0]  pc;
    logic [31:0] ins;
    logic        v;
    logic        e;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] W0 = 32'h08A7_0500;
  localparam logic [31:0] W1 = 32'h08A0_0500;
  localparam logic [31:0] W2 = 32'h08A1_0501;
  localparam logic [31:0] W3 = 32'h08A2_0502;
  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h1111_0001;
  localparam logic [31:0] A2 = 32'h1111_0002;
  localparam logic [31:0] B0 = 32'h2222_0000;
  localparam logic [31:0] B1 = 32'h2222_0001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input string nm, input logic [31:0] ins,
                      input logic v, input logic e);
    exp_t x;
    x.sel = sel; x.nm = nm; x.ins = ins; x.v = v; x.e = e;
    sb.push_back(x);
  endtask

  // drive a fetch-side cycle on the default build and queue its result
  task automatic fa(input logic fe, input logic fl, input logic [9:0] p,
                    input logic [31:0] ins, input logic v, input logic e, input string nm);
    fetch_en = fe; flush = fl; pc = p;
    push(1'b0, nm, ins, v, e);
  endtask

  task automatic fb(input logic fe, input logic [3:0] p,
                    input logic [31:0] ins, input logic v, input logic e, input string nm);
    b_fetch_en = fe; b_flush = 1'b0; b_pc = p;
    push(1'b1, nm, ins, v, e);
  endtask

  task automatic pop_check;
    exp_t x;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: queue empty, want an entry");
    end else begin
      x = sb.pop_front();
      if (x.sel == 1'b0) begin
        chk({x.nm, ".ins"}, instruction, x.ins);
        chk({x.nm, ".vld"}, {31'b0, instr_valid}, {31'b0, x.v});
        chk({x.nm, ".err"}, {31'b0, addr_err}, {31'b0, x.e});
      end else begin
        chk({x.nm, ".ins"}, b_instruction, x.ins);
        chk({x.nm, ".vld"}, {31'b0, b_instr_valid}, {31'b0, x.v});
        chk({x.nm, ".err"}, {31'b0, b_addr_err}, {31'b0, x.e});
      end
    end
  endtask

  task automatic fetch_step_a(input logic [9:0] p, input logic [31:0] ins, input string nm);
    fa(1'b1, 1'b0, p, ins, 1'b1, 1'b0, nm);
    tick();
    pop_check();
  endtask

  initial begin
    vec_t        tbl[12];
    logic [31:0] prog[4];

    prog[0] = W0; prog[1] = W1; prog[2] = W2; prog[3] = W3;
    tbl[0]  = '{1'b1, 1'b0, 10'd0, W0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 10'd1, W1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10'd2, W2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10'd3, W3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 10'd2, W2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 10'd3, W2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 10'd3, W2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 10'd0, W2, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 10'd1, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 10'd1, W1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 10'd0, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 10'd3, 32'h0, 1'b0, 1'b0};

    fetch_en = 0; flush = 0; pc = '0; load_en = 0; wr_valid = 0; wr_data = '0; wr_last = 0;
    b_fetch_en = 0; b_flush = 0; b_pc = '0; b_load_en = 0; b_wr_valid = 0; b_wr_data = '0;
    b_wr_last = 0;

    // reset state
    tick(); tick();
    chk("rst.ins",   instruction, 32'h0);
    chk("rst.vld",   {31'b0, instr_valid}, 32'h0);
    chk("rst.err",   {31'b0, addr_err}, 32'h0);
    chk("rst.rdy",   {31'b0, wr_ready}, 32'h0);
    chk("rst.done",  {31'b0, load_done}, 32'h0);
    chk("rst.cnt",   {21'b0, load_count}, 32'h0);
    chk("rst8.cnt",  {27'b0, b_load_count}, 32'h0);
    rst_n = 1'b1;
    tick();

    // load 4-word program terminated by wr_last
    load_en = 1'b1;
    tick();
    chk("load.rdy", {31'b0, wr_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = prog[i]; wr_last = (i == 3);
      tick();
      if (i < 3) chk($sformatf("load.done_low%0d", i), {31'b0, load_done}, 32'h0);
    end
    chk("load.done", {31'b0, load_done}, 32'h1);
    chk("load.cnt",  {21'b0, load_count}, 32'd4);
    chk("load.rdy_after", {31'b0, wr_ready}, 32'h0);
    load_en = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    tick();
    chk("load.done_pulse", {31'b0, load_done}, 32'h0);

    // fetch / stall / flush table
    foreach (tbl[i]) begin
      fa(tbl[i].fe, tbl[i].fl, tbl[i].pc, tbl[i].ins, tbl[i].v, tbl[i].e,
         $sformatf("vec%0d", i));
      tick();
      pop_check();
    end

    // load request with fetch_en in the same cycle: load wins
    load_en = 1'b1;
    fa(1'b1, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, "loadwins");
    tick();
    pop_check();
    fetch_en = 1'b0;

    // abort after 3 words, with a bubble carrying a stray wr_last
    wr_valid = 1'b1; wr_data = A0; tick();
    wr_data = A1; tick();
    wr_valid = 1'b0; wr_last = 1'b1; wr_data = 32'hBAD0_BAD0; tick();
    chk("bubble.done", {31'b0, load_done}, 32'h0);
    wr_valid = 1'b1; wr_last = 1'b0; wr_data = A2; tick();
    load_en = 1'b0; wr_data = 32'hDEAD_BEEF;
    #1;
    chk("abort.rdy", {31'b0, wr_ready}, 32'h0);
    tick();
    chk("abort.cnt",  {21'b0, load_count}, 32'd3);
    chk("abort.done", {31'b0, load_done}, 32'h0);
    wr_valid = 1'b0;
    tick();
    chk("abort.done2", {31'b0, load_done}, 32'h0);
    fetch_step_a(10'd0, A0, "abort.m0");
    fetch_step_a(10'd1, A1, "abort.m1");
    fetch_step_a(10'd2, A2, "abort.m2");
    fetch_step_a(10'd3, W3, "abort.m3");

    // reset in the middle of a load
    fetch_en = 1'b0; load_en = 1'b1;
    tick();
    wr_valid = 1'b1; wr_data = B0; tick();
    wr_data = B1; tick();
    wr_data = 32'hDEAD_0002;
    rst_n = 1'b0;
    #1;
    chk("mid.vld",  {31'b0, instr_valid}, 32'h0);
    chk("mid.cnt",  {21'b0, load_count}, 32'h0);
    chk("mid.rdy",  {31'b0, wr_ready}, 32'h0);
    chk("mid.done", {31'b0, load_done}, 32'h0);
    load_en = 1'b0; wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid.done2", {31'b0, load_done}, 32'h0);
    fetch_step_a(10'd0, B0, "mid.m0");
    fetch_step_a(10'd1, B1, "mid.m1");
    fetch_step_a(10'd2, A2, "mid.m2");
    fetch_en = 1'b0;

    // DEPTH=8: out-of-range fetch
    fb(1'b1, 4'd9, 32'h0, 1'b1, 1'b1, "d8.oor9");
    tick();
    pop_check();
    b_fetch_en = 1'b0;

    // DEPTH=8: 10 words offered without wr_last, only 8 accepted
    b_load_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      b_wr_valid = 1'b1; b_wr_data = 32'h100 + i;
      tick();
      if (i < 7) begin
        chk($sformatf("d8.done_low%0d", i), {31'b0, b_load_done}, 32'h0);
      end else begin
        chk("d8.done", {31'b0, b_load_done}, 32'h1);
        chk("d8.cnt",  {27'b0, b_load_count}, 32'd8);
        chk("d8.rdy",  {31'b0, b_wr_ready}, 32'h0);
        b_load_en = 1'b0; b_wr_valid = 1'b0;
        break;
      end
    end
    tick();
    chk("d8.done_pulse", {31'b0, b_load_done}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      fb(1'b1, 4'(i), 32'h100 + i, 1'b1, 1'b0, $sformatf("d8.m%0d", i));
      tick();
      pop_check();
    end
    fb(1'b1, 4'd8, 32'h0, 1'b1, 1'b1, "d8.oor8");
    tick();
    pop_check();
    fb(1'b1, 4'd7, 32'h107, 1'b1, 1'b0, "d8.back_in");
    tick();
    pop_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised synchronous instruction memory for the MIPS pipeline fetch stage, successor to the fixed-program ROM.
- Adds a runtime program-load port (valid/ready stream), fetch stall, pipeline flush to NOP, and out-of-range PC detection.
- Sits between the PC register and the IF/ID pipeline register; the loader is driven by the testbench or a boot controller.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 10, PC/word-address width in bits.
- DEPTH, 1024, number of words, DEPTH <= 2**ADDR_W.
- NOP_WORD, 32'h0000_0000, word emitted on flush, reset and out-of-range fetch (DATA_W bits).

Ports:
- CLK_SYS  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  1 = fetch at pc this cycle; 0 = stall, hold outputs.
- pc  in  ADDR_W  word address to fetch.
- flush  in  1  replace output with NOP_WORD, drop valid.
- instruction  out  DATA_W  registered instruction word.
- instr_valid  out  1  instruction holds a real fetched word.
- addr_err  out  1  registered; the last fetch had pc >= DEPTH.
- load_en  in  1  level; 1 requests or keeps load mode.
- wr_valid  in  1  loader word valid.
- wr_data  in  DATA_W  loader word.
- wr_last  in  1  marks the final word of the program.
- wr_ready  out  1  memory accepts a loader word.
- load_done  out  1  one-cycle pulse on normal load completion.
- load_count  out  ADDR_W+1  number of words written by the last load (completed or aborted).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - instruction=NOP_WORD; instr_valid=0; addr_err=0; wr_ready=0; load_done=0; load_count=0.
  - Write pointer wptr=0; state=RUN.
  - Memory array is not cleared; contents persist across reset.
- States: RUN, LOAD.
- RUN:
  - Read latency is 1 cycle: pc sampled at edge N appears on instruction after edge N.
  - Priority per edge: flush > fetch_en > hold.
  - flush=1: instruction=NOP_WORD, instr_valid=0, addr_err=0.
  - fetch_en=1, pc<DEPTH: instruction=mem[pc], instr_valid=1, addr_err=0.
  - fetch_en=1, pc>=DEPTH: instruction=NOP_WORD, instr_valid=1, addr_err=1.
  - fetch_en=0: instruction, instr_valid and addr_err hold.
  - wr_ready=0.
  - load_en=1 sampled: next state LOAD, wptr=0, instruction=NOP_WORD, instr_valid=0.
- LOAD:
  - wr_ready=1 combinationally while in LOAD with load_en=1.
  - Transfer = wr_valid & wr_ready: mem[wptr]=wr_data, wptr+1.
  - fetch_en, pc and flush are ignored; instruction=NOP_WORD, instr_valid=0.
  - Completion: transfer with wr_last=1, or transfer at wptr==DEPTH-1 (overflow guard, later words never written). Next state RUN; load_count=wptr+1; load_done=1 for exactly one cycle.
  - Abort: load_en=0 in LOAD. No write that cycle (wr_ready=0). Next state RUN; load_count=wptr; load_done stays 0.
  - wr_valid=0 cycles insert bubbles and do not advance wptr.
- Read-after-load: the first RUN fetch after completion returns the newly written data; no stale read.
- Simultaneous events:
  - load_en=1 with fetch_en=1 in RUN: load wins; no fetch issued.
  - wr_last on a non-transfer cycle (wr_valid=0) is ignored.
- Reset mid-load: returns to RUN immediately. Words already written are kept; load_done is not pulsed; load_count=0.
- Out-of-range write: impossible, since wptr never exceeds DEPTH-1.

Test Plan:
- Reset then load 4 words (0x08A7_0500, 0x08A0_0500, 0x08A1_0501, 0x08A2_0502), last with wr_last -> load_done pulses once, load_count=4. Then fetch pc=0..3 -> same words one cycle later, instr_valid=1.
- Stall: fetch pc=2, then fetch_en=0 for 3 cycles while pc changes to 3 -> instruction stays 0x08A1_0501, valid stays 1.
- Flush during fetch_en=1, pc=1 -> next cycle instruction=0x0000_0000, instr_valid=0. Release flush -> mem[1] appears.
- DEPTH=8 build: fetch pc=9 -> instruction=NOP_WORD, addr_err=1. Load 10 words with no wr_last -> 8 accepted, load_done pulses, load_count=8, wr_ready=0 afterwards.
- Abort: load 3 words, drop load_en -> load_count=3, no load_done pulse, words 0..2 updated, word 3 retains its old value.
- Assert rst_n=0 mid-load after 2 words, then release -> state RUN, instr_valid=0, load_count=0, the 2 written words readable at pc=0,1.
